upgrade_spawn_scheduler: RTL and testbench
==========================================

Name: upgrade_spawn_scheduler

Overview:
Lifecycle controller for the single on-screen upgrade pickup. It sequences the pickup through three phases: cooldown, spawned and visible, and held by a player. It also arbitrates simultaneous pickup by P1/P2 with round-robin fairness. It drives the upgrade position/size and owner into the armor attachment and renderer, and expires or consumes the upgrade on timeout or an absorbed hit.

Parameters:
COOLDOWN_FRAMES, 180, frames with no upgrade before the next spawn (1..1023)
DESPAWN_FRAMES, 300, frames an uncollected upgrade stays visible (1..1023)
LIFETIME_FRAMES, 600, frames a collected upgrade stays attached (1..1023)
UPGRADE_SIZE, 8, half-width of the pickup box in pixels
LFSR_SEED, 8'hA5, spawn-slot LFSR reset value (must be nonzero)

Ports:
frame_clk  in  1  frame-rate clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-low reset
BallX, BallY  in  10  P1 centre
Ball2X, Ball2Y  in  10  P2 centre
hit_p1, hit_p2  in  1  level, sampled per frame: the player's armor absorbed a hit this frame
UpgradeX, UpgradeY  out  10  upgrade centre (valid while upgrade_visible)
Upgrade_Size  out  10  constant UPGRADE_SIZE
upgrade_visible  out  1  upgrade is drawn and collectible
owner  out  2  one-hot holder: 00 none, 01 P1, 10 P2
collect_pulse  out  1  one-frame pulse on grant; downstream clears/re-arms armor
sched_state  out  2  current state (debug)

Behaviour:
- States: COOLDOWN=0, SPAWNED=1, HELD=2. Encoding 3 is unreachable and recovers to COOLDOWN with a reload.
- Reset (Reset=0, async): state COOLDOWN, timer=COOLDOWN_FRAMES, upgrade_visible=0, owner=00, collect_pulse=0, UpgradeX/Y=0, lfsr=LFSR_SEED, rr_pri=0 (P1 preferred). Reset mid-operation aborts any phase immediately.
- Timer: 10-bit down-counter. It decrements by 1 per edge while nonzero. The "expire" event is timer==0 sampled at an edge; the transition and reload happen on that edge.
- LFSR: 8-bit Fibonacci, shift left, new bit = b7^b5^b4^b3. It advances every edge in every state.
- COOLDOWN: on expire, latch (UpgradeX,UpgradeY)=SPAWN_TABLE[lfsr[1:0]], upgrade_visible=1, timer=DESPAWN_FRAMES, go to SPAWNED. Visible first asserts on edge COOLDOWN_FRAMES+1 after reset release.
- SPAWNED hit test, per player: |bx-UpgradeX|<=UPGRADE_SIZE and |by-UpgradeY|<=UPGRADE_SIZE. Compute as bx>=UpgradeX-UPGRADE_SIZE and bx<=UpgradeX+UPGRADE_SIZE, same for y. Table entries guarantee no unsigned wrap.
  - Only P1 hits: grant P1. Only P2 hits: grant P2.
  - Both hit in the same frame: grant rr_pri's player (0=P1, 1=P2), then toggle rr_pri. rr_pri toggles only on contested grants.
  - Grant, registered on the same edge: owner=winner, collect_pulse=1 for exactly one frame, upgrade_visible=0, timer=LIFETIME_FRAMES, go to HELD.
  - Grant beats expire when both occur in the same frame.
  - Expire without a grant: upgrade_visible=0, timer=COOLDOWN_FRAMES, go to COOLDOWN.
- HELD: release on an owner's hit (hit_p1 when owner=01, hit_p2 when owner=10) or on expire. Release: owner=00, timer=COOLDOWN_FRAMES, go to COOLDOWN. Hits from the non-owner are ignored. Ball overlap is ignored in HELD and COOLDOWN.
- collect_pulse is 0 in every frame that is not a grant frame.
- UpgradeX/Y hold their last latched value outside SPAWNED.

Decomposition:
- Package upgrade_pkg holds:
  - the state enum and owner one-hot constants (OWNER_NONE/P1/P2);
  - the direction codes (00 L, 01 R, 10 D, 11 U);
  - SPAWN_TABLE[4] = (160,120), (480,120), (160,360), (480,360);
  - the LFSR tap mask.
- One sub-module: upgrade_lfsr (8-bit, seed parameter, advance every clock, async active-low reset).

Test Plan:
1. COOLDOWN=4, no balls near the table: upgrade_visible rises on the 5th edge after reset release. UpgradeX/Y equal SPAWN_TABLE[lfsr[1:0]] from the reference LFSR model; sched_state=1.
2. Spawned at (160,120), BallX=168, BallY=112 (edge of box): at the next edge owner=01, collect_pulse high for 1 frame, visible=0. BallX=169 instead gives no grant.
3. Both balls at the upgrade centre in the same frame, twice across two spawns: first grant owner=01, second grant owner=10 (round-robin). rr_pri is unchanged by an uncontested grant in between.
4. DESPAWN=5, nobody collects: visible falls after 6 frames with state COOLDOWN. A ball arriving exactly on the expire frame is granted (grant beats expire).
5. LIFETIME=6, held by P1: hit_p2 pulse changes nothing; hit_p1 pulse gives owner=00 and COOLDOWN on the next edge. Without hits, release occurs 7 frames after the grant.
6. Reset asserted low mid-HELD, asynchronously between edges: owner=00, visible=0, collect_pulse=0 immediately; after release the spawn timing matches scenario 1.

Source files
------------

// File: rtl/upgrade_pkg.sv
// Shared types and constants for the upgrade pickup scheduler: lifecycle states,
// owner codes, spawn slots and the spawn-slot LFSR taps.
package upgrade_pkg;

  typedef enum logic [1:0] {
    COOLDOWN = 2'd0,
    SPAWNED  = 2'd1,
    HELD     = 2'd2,
    ST_BAD   = 2'd3
  } sched_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P1   = 2'b01;
  localparam logic [1:0] OWNER_P2   = 2'b10;

  typedef enum logic [1:0] {
    DIR_L = 2'b00,
    DIR_R = 2'b01,
    DIR_D = 2'b10,
    DIR_U = 2'b11
  } dir_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } spawn_pt_t;

  // b7^b5^b4^b3 feedback
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic spawn_pt_t spawn_pt(input logic [1:0] slot);
    case (slot)
      2'd0:    spawn_pt = '{x: 10'd160, y: 10'd120};
      2'd1:    spawn_pt = '{x: 10'd480, y: 10'd120};
      2'd2:    spawn_pt = '{x: 10'd160, y: 10'd360};
      default: spawn_pt = '{x: 10'd480, y: 10'd360};
    endcase
  endfunction

  // Table entries keep centre +/- size inside 10 bits, so no wrap here.
  function automatic logic in_span(input logic [9:0] b, input logic [9:0] c,
                                   input logic [9:0] sz);
    in_span = (b >= c - sz) && (b <= c + sz);
  endfunction

endpackage

// File: rtl/upgrade_lfsr.sv
// Free-running 8-bit Fibonacci LFSR choosing the next spawn slot.
module upgrade_lfsr
  import upgrade_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       frame_clk,
  input  logic       Reset,
  output logic [1:0] slot
);

  logic [7:0] lfsr;

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) lfsr <= SEED;
    else        lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  assign slot = lfsr[1:0];

endmodule

// File: rtl/upgrade_spawn_scheduler.sv
// Upgrade pickup lifecycle: cooldown -> spawned -> held, with round-robin
// arbitration when both players touch the pickup in the same frame.
module upgrade_spawn_scheduler
  import upgrade_pkg::*;
#(
  parameter int         COOLDOWN_FRAMES = 180,
  parameter int         DESPAWN_FRAMES  = 300,
  parameter int         LIFETIME_FRAMES = 600,
  parameter int         UPGRADE_SIZE    = 8,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] Ball2X,
  input  logic [9:0] Ball2Y,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic [9:0] UpgradeX,
  output logic [9:0] UpgradeY,
  output logic [9:0] Upgrade_Size,
  output logic       upgrade_visible,
  output logic [1:0] owner,
  output logic       collect_pulse,
  output logic [1:0] sched_state
);

  localparam logic [9:0] CD_LOAD = 10'(COOLDOWN_FRAMES);
  localparam logic [9:0] DS_LOAD = 10'(DESPAWN_FRAMES);
  localparam logic [9:0] LT_LOAD = 10'(LIFETIME_FRAMES);
  localparam logic [9:0] SZ      = 10'(UPGRADE_SIZE);

  sched_state_e state_q, state_d;
  logic [9:0]   timer_q;
  spawn_pt_t    pos_q;
  logic [1:0]   owner_q;
  logic         pulse_q;
  logic         rr_pri_q;
  logic [1:0]   slot;

  logic       expire, hit1, hit2, any_hit, contested, release_hold;
  logic [1:0] winner;

  upgrade_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .slot      (slot)
  );

  assign expire    = (timer_q == 10'd0);
  assign hit1      = in_span(BallX, pos_q.x, SZ)  && in_span(BallY, pos_q.y, SZ);
  assign hit2      = in_span(Ball2X, pos_q.x, SZ) && in_span(Ball2Y, pos_q.y, SZ);
  assign any_hit   = hit1 | hit2;
  assign contested = hit1 & hit2;
  assign winner    = contested ? (rr_pri_q ? OWNER_P2 : OWNER_P1)
                               : (hit1 ? OWNER_P1 : OWNER_P2);
  assign release_hold = expire || (owner_q == OWNER_P1 && hit_p1)
                               || (owner_q == OWNER_P2 && hit_p2);

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= COOLDOWN;
      timer_q  <= CD_LOAD;
      pos_q    <= '0;
      owner_q  <= OWNER_NONE;
      pulse_q  <= 1'b0;
      rr_pri_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= 1'b0;
      // Every state change reloads the timer for the phase being entered.
      if (state_d != state_q || state_q == ST_BAD) begin
        case (state_d)
          SPAWNED: timer_q <= DS_LOAD;
          HELD:    timer_q <= LT_LOAD;
          default: timer_q <= CD_LOAD;
        endcase
      end else if (!expire) begin
        timer_q <= timer_q - 10'd1;
      end
      if (state_q == COOLDOWN && expire) pos_q <= spawn_pt(slot);
      if (state_q == SPAWNED && any_hit) begin
        owner_q <= winner;
        pulse_q <= 1'b1;
        if (contested) rr_pri_q <= ~rr_pri_q;
      end
      if ((state_q == HELD && release_hold) || state_q == ST_BAD) owner_q <= OWNER_NONE;
    end
  end

  // Grant outranks expiry in SPAWNED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COOLDOWN: if (expire) state_d = SPAWNED;
      SPAWNED:  if (any_hit) state_d = HELD;
                else if (expire) state_d = COOLDOWN;
      HELD:     if (release_hold) state_d = COOLDOWN;
      default:  state_d = COOLDOWN;
    endcase
  end

  always_comb begin
    upgrade_visible = (state_q == SPAWNED);
    owner           = owner_q;
    collect_pulse   = pulse_q;
    sched_state     = state_q;
    UpgradeX        = pos_q.x;
    UpgradeY        = pos_q.y;
    Upgrade_Size    = SZ;
  end

endmodule

// File: tb/tb_upgrade_spawn_scheduler.sv
// Bench for upgrade_spawn_scheduler: directed lifecycle scenarios, then random
// play, all compared each frame against a deadline-based behavioural model.
module tb_upgrade_spawn_scheduler;

  localparam int CD = 4, DS = 5, LT = 6;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic [9:0] BallX = '0, BallY = '0, Ball2X = '0, Ball2Y = '0;
  logic       hit_p1 = 1'b0, hit_p2 = 1'b0;
  logic [9:0] UpgradeX, UpgradeY, Upgrade_Size;
  logic       upgrade_visible, collect_pulse;
  logic [1:0] owner, sched_state;

  upgrade_spawn_scheduler #(
    .COOLDOWN_FRAMES(CD), .DESPAWN_FRAMES(DS), .LIFETIME_FRAMES(LT),
    .UPGRADE_SIZE(8), .LFSR_SEED(8'hA5)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .BallX(BallX), .BallY(BallY), .Ball2X(Ball2X), .Ball2Y(Ball2Y),
    .hit_p1(hit_p1), .hit_p2(hit_p2),
    .UpgradeX(UpgradeX), .UpgradeY(UpgradeY), .Upgrade_Size(Upgrade_Size),
    .upgrade_visible(upgrade_visible), .owner(owner),
    .collect_pulse(collect_pulse), .sched_state(sched_state)
  );

  always #5 frame_clk = ~frame_clk;

  int n_chk = 0, n_err = 0;

  // Model: phase 0 idle, 1 on screen, 2 held; each phase ends at an absolute frame number.
  int       m_phase, m_edge, m_deadline, m_x, m_y, m_owner;
  bit       m_pulse, m_rr;
  bit [7:0] m_lfsr;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit near(input int b, input int c);
    return ((b > c) ? b - c : c - b) <= 8;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_edge = 0; m_deadline = CD + 1;
    m_x = 0; m_y = 0; m_owner = 0; m_pulse = 0; m_rr = 0; m_lfsr = 8'hA5;
  endtask

  task automatic model_step();
    bit expire, h1, h2;
    m_edge++;
    expire  = (m_edge == m_deadline);
    m_pulse = 0;
    if (m_phase == 0) begin
      if (expire) begin
        m_x = (m_lfsr[0]) ? 480 : 160;
        m_y = (m_lfsr[1]) ? 360 : 120;
        m_phase = 1; m_deadline = m_edge + DS + 1;
      end
    end else if (m_phase == 1) begin
      h1 = near(BallX, m_x) && near(BallY, m_y);
      h2 = near(Ball2X, m_x) && near(Ball2Y, m_y);
      if (h1 || h2) begin
        if (h1 && h2) begin m_owner = m_rr ? 2 : 1; m_rr = !m_rr; end
        else m_owner = h1 ? 1 : 2;
        m_pulse = 1; m_phase = 2; m_deadline = m_edge + LT + 1;
      end else if (expire) begin
        m_phase = 0; m_deadline = m_edge + CD + 1;
      end
    end else begin
      if (expire || (m_owner == 1 && hit_p1) || (m_owner == 2 && hit_p2)) begin
        m_owner = 0; m_phase = 0; m_deadline = m_edge + CD + 1;
      end
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge frame_clk);
      #1;
      if (!Reset) model_reset();
      else model_step();
      chk("state", sched_state, m_phase);
      chk("visible", upgrade_visible, (m_phase == 1) ? 1 : 0);
      chk("owner", owner, m_owner);
      chk("pulse", collect_pulse, m_pulse);
      chk("upgx", UpgradeX, m_x);
      chk("upgy", UpgradeY, m_y);
    end
  end

  task automatic balls_away();
    BallX = 0; BallY = 0; Ball2X = 0; Ball2Y = 0;
  endtask

  task automatic wait_spawn();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge frame_clk);
      if (m_phase == 1) ok = 1;
    end
    chk("spawn_timeout", ok, 1);
  endtask

  task automatic pulse_hit(input bit p2);
    if (p2) hit_p2 = 1; else hit_p1 = 1;
    @(negedge frame_clk);
    hit_p1 = 0; hit_p2 = 0;
  endtask

  initial begin
    repeat (2) @(negedge frame_clk);
    chk("rst_vis", upgrade_visible, 0);
    chk("rst_owner", owner, 0);
    chk("size", Upgrade_Size, 8);
    Reset = 1;
    // Spawn after CD+1 edges at slot 0 of the reference LFSR.
    repeat (CD) @(negedge frame_clk);
    chk("pre_spawn_vis", upgrade_visible, 0);
    @(negedge frame_clk);
    chk("spawn_vis", upgrade_visible, 1);
    chk("spawn_x", UpgradeX, 160);
    chk("spawn_y", UpgradeY, 120);
    chk("spawn_state", sched_state, 1);
    chk("model_x", m_x, 160);
    // Box edge: 169 is one pixel outside, 168 is inside.
    BallX = 169; BallY = 112;
    @(negedge frame_clk);
    chk("outside_owner", owner, 0);
    chk("outside_vis", upgrade_visible, 1);
    BallX = 168;
    @(negedge frame_clk);
    chk("edge_owner", owner, 1);
    chk("edge_pulse", collect_pulse, 1);
    chk("edge_vis", upgrade_visible, 0);
    balls_away();
    @(negedge frame_clk);
    chk("pulse_once", collect_pulse, 0);
    pulse_hit(1);
    chk("nonowner_hit", owner, 1);
    pulse_hit(0);
    chk("owner_hit_owner", owner, 0);
    chk("owner_hit_state", sched_state, 0);

    // Contested grant, then lifetime expiry.
    wait_spawn();
    BallX = 10'(m_x); BallY = 10'(m_y); Ball2X = 10'(m_x); Ball2Y = 10'(m_y);
    @(negedge frame_clk);
    chk("rr1_owner", owner, 1);
    balls_away();
    repeat (LT) @(negedge frame_clk);
    chk("life_held", sched_state, 2);
    @(negedge frame_clk);
    chk("life_rel_state", sched_state, 0);
    chk("life_rel_owner", owner, 0);

    // Uncontested P2 grant leaves the priority pointer alone.
    wait_spawn();
    Ball2X = 10'(m_x); Ball2Y = 10'(m_y);
    @(negedge frame_clk);
    chk("solo_p2", owner, 2);
    balls_away();
    pulse_hit(1);
    wait_spawn();
    BallX = 10'(m_x); BallY = 10'(m_y); Ball2X = 10'(m_x); Ball2Y = 10'(m_y);
    @(negedge frame_clk);
    chk("rr2_owner", owner, 2);
    balls_away();
    pulse_hit(1);

    // Grant on the expiry frame wins.
    wait_spawn();
    repeat (DS) @(negedge frame_clk);
    chk("late_vis", upgrade_visible, 1);
    BallX = 10'(m_x); BallY = 10'(m_y);
    @(negedge frame_clk);
    chk("late_grant", owner, 1);
    chk("late_state", sched_state, 2);
    balls_away();
    pulse_hit(0);

    // Uncollected despawn.
    wait_spawn();
    repeat (DS) @(negedge frame_clk);
    chk("despawn_vis_hold", upgrade_visible, 1);
    @(negedge frame_clk);
    chk("despawn_vis", upgrade_visible, 0);
    chk("despawn_state", sched_state, 0);

    // Asynchronous reset while held.
    wait_spawn();
    BallX = 10'(m_x); BallY = 10'(m_y);
    @(negedge frame_clk);
    balls_away();
    @(negedge frame_clk);
    chk("pre_rst_owner", owner, 1);
    #2 Reset = 0;
    #1;
    chk("arst_owner", owner, 0);
    chk("arst_vis", upgrade_visible, 0);
    chk("arst_pulse", collect_pulse, 0);
    chk("arst_state", sched_state, 0);
    repeat (2) @(negedge frame_clk);
    Reset = 1;
    repeat (CD) @(negedge frame_clk);
    chk("re_pre_vis", upgrade_visible, 0);
    @(negedge frame_clk);
    chk("re_vis", upgrade_visible, 1);
    chk("re_x", UpgradeX, 160);
    chk("re_y", UpgradeY, 120);

    // Random play around the pickup box boundary.
    for (int i = 0; i < 3000; i++) begin
      @(negedge frame_clk);
      if ($urandom_range(0, 2) != 0) begin
        BallX = 10'(m_x + $urandom_range(0, 20) - 10);
        BallY = 10'(m_y + $urandom_range(0, 20) - 10);
      end else begin
        BallX = 10'($urandom_range(0, 639)); BallY = 10'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 2) != 0) begin
        Ball2X = 10'(m_x + $urandom_range(0, 20) - 10);
        Ball2Y = 10'(m_y + $urandom_range(0, 20) - 10);
      end else begin
        Ball2X = 10'($urandom_range(0, 639)); Ball2Y = 10'($urandom_range(0, 479));
      end
      hit_p1 = ($urandom_range(0, 7) == 0);
      hit_p2 = ($urandom_range(0, 7) == 0);
    end
    @(negedge frame_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
